// File: rtl/sram_rd_streamer.sv
// Burst read sequencer for the 16x64 SRAM. Reads stream into a small FIFO
// and are offered downstream on valid/ready; reads throttle on back-pressure.
module sram_rd_streamer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  input  logic [DATA_W-1:0] sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic              inflight, inflight_last;
  ent_t              mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W:0]   len_c;
  logic              issue, push, pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign len_c     = (length > MAX_LEN) ? MAX_LEN : length;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight;

  // Count the word in flight as occupied so a full FIFO always stalls reads.
  assign issue = ~reset & (state == RUN) & (remaining != '0) &
                 ((count + CW'(inflight) - CW'(pop)) < CW'(FIFO_DEPTH));

  assign sram_cen = ~issue;
  assign sram_wen = 1'b1;
  assign sram_a   = addr;
  assign out_data = out_valid ? mem[rd_ptr].data : '0;
  assign out_last = out_valid & mem[rd_ptr].last;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: inflight_last, data: sram_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == ONE);
      if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE: if (start) begin
          if (len_c != '0) begin
            addr      <= base_addr;
            remaining <= len_c;
            state     <= RUN;
          end else begin
            state <= DONE;
          end
        end
        RUN:   if (issue && (remaining == ONE)) state <= DRAIN;
        DRAIN: if (pop && out_last) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == CW'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer: SRAM model, expected-beat queue scoreboard and
// directed bursts with hand-computed timing and data.
module tb_sram_rd_streamer;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_q = '0;
  logic          out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  sram_rd_streamer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_q(sram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  // SRAM: Q updates on the read edge, so it is valid the following cycle.
  logic [DW-1:0] mem [16];
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard: expected beats {last,data} and expected read addresses.
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] exp_a [$];
  int            issued = 0, accepted = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_a.delete();
        issued = 0;
        accepted = 0;
        prev_stall = 1'b0;
        chk("cen_in_reset", sram_cen, 1);
      end else begin
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
          chk("stall_last", out_last, prev_last);
        end
        if (!sram_cen) begin
          issued++;
          chk("cen_only_busy", busy, 1);
          if (exp_a.size() == 0) chk("read_expected", 64'(exp_a.size()), 1);
          else chk("sram_a", sram_a, exp_a.pop_front());
        end
        if (out_valid && out_ready) begin
          accepted++;
          if (exp_q.size() == 0) chk("beat_expected", 64'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e[DW-1:0]);
            chk("out_last", out_last, e[DW]);
          end
        end
        chk("outstanding_le_depth", 64'((issued - accepted) <= FD), 1);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // Per-burst observations, k = edges since the edge that accepted start.
  int            r_beats, r_first, r_lasths, r_done, r_dones, r_end, r_cenlow;
  logic          r_abort;
  logic [DW-1:0] r_fdata;

  // mode 0: ready=1; 1: ready 0 for 6 cycles then 1010..;
  // 2: ready=1 plus a stray start while busy; 3: reset after 6 beats.
  task automatic burst(input logic [AW-1:0] b, input logic [AW:0] l, input int mode);
    int n;
    logic [AW-1:0] a;
    n = (l > 16) ? 16 : int'(l);
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      exp_q.push_back({(i == n-1), mem[a]});
      exp_a.push_back(a);
    end
    r_beats = 0; r_first = -1; r_lasths = -1; r_done = -1; r_dones = 0;
    r_end = -1; r_cenlow = 0; r_abort = 1'b0; r_fdata = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; length = l; out_ready = (mode != 1);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!sram_cen) r_cenlow++;
      if (out_valid && r_first < 0) begin r_first = k; r_fdata = out_data; end
      if (out_valid && out_ready) begin
        r_beats++;
        if (out_last) r_lasths = k;
      end
      if (done) begin r_dones++; r_done = k; end
      if (mode == 1 && k >= 2 && k <= 5) chk("stall_no_read", sram_cen, 1);
      if (r_dones > 0 && !busy) begin r_end = k; break; end
      @(posedge clk); #1;
      if (mode == 1) out_ready = (k + 1 >= 6) && (((k + 1 - 6) % 2) == 0);
      if (mode == 2) begin
        start = (k + 1 == 3);
        if (k + 1 == 3) begin base_addr = 4'd7; length = 5'd2; end
      end
      if (mode == 3 && r_beats == 6) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_cen", sram_cen, 1);
        chk("abort_done", done, 0);
        r_abort = 1'b1;
        break;
      end
    end
    if (!r_abort) chk("burst_finished", 64'(r_end >= 0), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'h1111_1111_1111_1111 * 64'(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_a", sram_a, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    burst(4'd0, 5'd16, 0);
    chk("t1_beats", r_beats, 16);
    chk("t1_first", r_first, 2);
    chk("t1_first_data", r_fdata, 64'h0);
    chk("t1_last_hs", r_lasths, 17);
    chk("t1_done_at", r_done, 18);
    chk("t1_done_cnt", r_dones, 1);
    chk("t1_busy_fall", r_end, 19);

    burst(4'd14, 5'd4, 0);
    chk("t2_beats", r_beats, 4);
    chk("t2_first_data", r_fdata, 64'hEEEE_EEEE_EEEE_EEEE);
    chk("t2_last_hs", r_lasths, 5);
    chk("t2_done_at", r_done, 6);

    burst(4'd0, 5'd8, 1);
    chk("t3_beats", r_beats, 8);
    chk("t3_done_cnt", r_dones, 1);

    burst(4'd5, 5'd0, 0);
    chk("t4_beats", r_beats, 0);
    chk("t4_no_valid", r_first, -1);
    chk("t4_no_read", r_cenlow, 0);
    chk("t4_done_at", r_done, 0);
    chk("t4_done_cnt", r_dones, 1);

    burst(4'd0, 5'd20, 2);
    chk("t5_beats", r_beats, 16);
    chk("t5_reads", r_cenlow, 16);
    chk("t5_done_cnt", r_dones, 1);

    burst(4'd0, 5'd16, 3);
    chk("t6_aborted", r_abort, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t6_idle_done", done, 0);
      chk("t6_idle_busy", busy, 0);
    end
    burst(4'd3, 5'd2, 0);
    chk("t6_beats", r_beats, 2);
    chk("t6_first_data", r_fdata, 64'h3333_3333_3333_3333);
    chk("t6_last_hs", r_lasths, 3);

    chk("beats_left", 64'(exp_q.size()), 0);
    chk("reads_left", 64'(exp_a.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
